// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared constants and state types for the RS-232 echo design.
// Holds the default bit timing (100 MHz clock, 9600 baud), the byte width,
// counter widths and the receiver/transmitter FSM state enums.
// No ports: imported by uart_rx, uart_tx and rs232_echo_top.
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int CLK_FREQ_DEF = 100_000_000;
    localparam int BAUD_DEF     = 9600;

    // Integer division: 100e6 / 9600 = 10416 cycles per bit.
    localparam int CLKS_PER_BIT = CLK_FREQ_DEF / BAUD_DEF;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;

    localparam int DATA_W    = 8;
    localparam int CNT_W     = 14;
    localparam int BIT_CNT_W = 3;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

endpackage

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
// 8N1 receiver. The serial input is brought into the clock domain through a
// 2-FF synchronizer, a falling edge starts a frame, the start bit is
// re-checked half a bit later (short lows are rejected as glitches), data
// bits are sampled once per bit period LSB first and the stop bit must be 1
// for the byte to be accepted.
// Ports:
//   clk_i      system clock
//   rst_i      synchronous active-low reset
//   rxd_i      asynchronous serial input, idle high
//   data_o     last correctly framed byte
//   txstart_o  one-cycle strobe when data_o has been updated
// ----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
    parameter int HALF_BIT     = uart_pkg::HALF_BIT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rxd_i,
    output logic [DATA_W-1:0] data_o,
    output logic              txstart_o
);

    localparam logic [CNT_W-1:0]     LAST_TICK = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]     HALF_TICK = CNT_W'(HALF_BIT - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(DATA_W - 1);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    rx_state_e             state_q,   state_d;
    logic [CNT_W-1:0]      baudCnt_q, baudCnt_d;
    logic [BIT_CNT_W-1:0]  bitCnt_q,  bitCnt_d;
    logic [DATA_W-1:0]     shift_q,   shift_d;
    logic [DATA_W-1:0]     data_q,    data_d;
    logic                  txstart_q, txstart_d;

    // Synchronizer plus one extra delayed copy for falling-edge detection.
    // All three reset to the idle line level so a reset never looks like a
    // start edge.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rxd_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Receiver state and datapath registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= RX_IDLE;
            baudCnt_q <= '0;
            bitCnt_q  <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            txstart_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            baudCnt_q <= baudCnt_d;
            bitCnt_q  <= bitCnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            txstart_q <= txstart_d;
        end
    end

    // Next-state logic. The baud counter restarts at every state change so
    // each sample lands a fixed number of cycles after the detected edge:
    // half a bit for the start check, then one full bit per data/stop bit.
    always_comb begin
        state_d   = state_q;
        baudCnt_d = baudCnt_q;
        bitCnt_d  = bitCnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        txstart_d = 1'b0;

        unique case (state_q)
            RX_IDLE: begin
                baudCnt_d = '0;
                bitCnt_d  = '0;
                if (prev_q && !sync2_q) begin
                    state_d = RX_START;
                end
            end

            RX_START: begin
                if (baudCnt_q == HALF_TICK) begin
                    baudCnt_d = '0;
                    // A line already back high mid start bit was a glitch.
                    if (sync2_q) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_DATA;
                    end
                end else begin
                    baudCnt_d = baudCnt_q + CNT_W'(1);
                end
            end

            RX_DATA: begin
                if (baudCnt_q == LAST_TICK) begin
                    baudCnt_d = '0;
                    shift_d   = {sync2_q, shift_q[DATA_W-1:1]};
                    if (bitCnt_q == LAST_BIT) begin
                        state_d = RX_STOP;
                    end else begin
                        bitCnt_d = bitCnt_q + BIT_CNT_W'(1);
                    end
                end else begin
                    baudCnt_d = baudCnt_q + CNT_W'(1);
                end
            end

            RX_STOP: begin
                if (baudCnt_q == LAST_TICK) begin
                    baudCnt_d = '0;
                    state_d   = RX_IDLE;
                    // A low stop bit is a framing error: drop the byte.
                    if (sync2_q) begin
                        data_d    = shift_q;
                        txstart_d = 1'b1;
                    end
                end else begin
                    baudCnt_d = baudCnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    assign data_o    = data_q;
    assign txstart_o = txstart_q;

endmodule

// File: rtl/uart_tx.sv
// ----------------------------------------------------------------------------
// uart_tx
// 8N1 transmitter with a one-byte holding buffer. A byte offered while a
// frame is in flight is parked in the buffer and sent on the cycle after the
// transmitter returns to idle; a further byte arriving while the buffer is
// full replaces the parked one.
// Ports:
//   clk_i      system clock
//   rst_i      synchronous active-low reset
//   data_i     byte to send, valid with txstart_i
//   txstart_i  one-cycle request to send data_i
//   txd_o      registered serial output, idle high
// ----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              txstart_i,
    output logic              txd_o
);

    localparam logic [CNT_W-1:0]     LAST_TICK = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(DATA_W - 1);

    tx_state_e             state_q,   state_d;
    logic [CNT_W-1:0]      baudCnt_q, baudCnt_d;
    logic [BIT_CNT_W-1:0]  bitCnt_q,  bitCnt_d;
    logic [DATA_W-1:0]     shift_q,   shift_d;
    logic [DATA_W-1:0]     hold_q,    hold_d;
    logic                  pending_q, pending_d;
    logic                  txd_q,     txd_d;

    // Transmitter registers. The output bit itself is a flop so the line
    // never carries combinational glitches, and reset forces it high at once.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= TX_IDLE;
            baudCnt_q <= '0;
            bitCnt_q  <= '0;
            shift_q   <= '0;
            hold_q    <= '0;
            pending_q <= 1'b0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            baudCnt_q <= baudCnt_d;
            bitCnt_q  <= bitCnt_d;
            shift_q   <= shift_d;
            hold_q    <= hold_d;
            pending_q <= pending_d;
            txd_q     <= txd_d;
        end
    end

    // Next-state logic. The next line level is computed one cycle ahead so
    // that the registered output changes exactly on bit boundaries; each bit
    // lasts CLKS_PER_BIT cycles.
    always_comb begin
        state_d   = state_q;
        baudCnt_d = baudCnt_q;
        bitCnt_d  = bitCnt_q;
        shift_d   = shift_q;
        hold_d    = hold_q;
        pending_d = pending_q;
        txd_d     = txd_q;

        unique case (state_q)
            TX_IDLE: begin
                baudCnt_d = '0;
                bitCnt_d  = '0;
                txd_d     = 1'b1;
                // The parked byte is older than any new request.
                if (pending_q) begin
                    shift_d   = hold_q;
                    pending_d = 1'b0;
                    state_d   = TX_START;
                    txd_d     = 1'b0;
                end else if (txstart_i) begin
                    shift_d = data_i;
                    state_d = TX_START;
                    txd_d   = 1'b0;
                end
            end

            TX_START: begin
                if (baudCnt_q == LAST_TICK) begin
                    baudCnt_d = '0;
                    txd_d     = shift_q[0];
                    shift_d   = shift_q >> 1;
                    state_d   = TX_DATA;
                end else begin
                    baudCnt_d = baudCnt_q + CNT_W'(1);
                end
            end

            TX_DATA: begin
                if (baudCnt_q == LAST_TICK) begin
                    baudCnt_d = '0;
                    if (bitCnt_q == LAST_BIT) begin
                        txd_d   = 1'b1;
                        state_d = TX_STOP;
                    end else begin
                        txd_d    = shift_q[0];
                        shift_d  = shift_q >> 1;
                        bitCnt_d = bitCnt_q + BIT_CNT_W'(1);
                    end
                end else begin
                    baudCnt_d = baudCnt_q + CNT_W'(1);
                end
            end

            TX_STOP: begin
                txd_d = 1'b1;
                if (baudCnt_q == LAST_TICK) begin
                    baudCnt_d = '0;
                    state_d   = TX_IDLE;
                end else begin
                    baudCnt_d = baudCnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = TX_IDLE;
                txd_d   = 1'b1;
            end
        endcase

        // Park the request unless it was taken straight into a frame above.
        // Evaluated after the case so that a request arriving in the same
        // cycle the old parked byte is launched refills the buffer.
        if (txstart_i && !((state_q == TX_IDLE) && !pending_q)) begin
            hold_d    = data_i;
            pending_d = 1'b1;
        end
    end

    assign txd_o = txd_q;

endmodule

// File: rtl/rs232_echo_top.sv
// ----------------------------------------------------------------------------
// rs232_echo_top
// Serial loopback: every correctly framed 8N1 byte received on RXD_i is
// retransmitted unchanged on TXD_o. Only wires a receiver to a transmitter.
// Ports:
//   clk_i  system clock (CLK_FREQ Hz)
//   rst_i  synchronous active-low reset
//   RXD_i  asynchronous serial input, idle high
//   TXD_o  serial output, idle high
// ----------------------------------------------------------------------------
module rs232_echo_top
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic RXD_i,
    output logic TXD_o
);

    logic [DATA_W-1:0] rxData;
    logic              txStart;

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .HALF_BIT     (CLKS_PER_BIT / 2)
    ) uRx (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .rxd_i     (RXD_i),
        .data_o    (rxData),
        .txstart_o (txStart)
    );

    uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) uTx (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .data_i    (rxData),
        .txstart_i (txStart),
        .txd_o     (TXD_o)
    );

endmodule

// File: tb/tb_rs232_echo_top.sv
// ----------------------------------------------------------------------------
// tb_rs232_echo_top
// Directed bench for the serial echo. The bit rate is scaled down
// (16 clocks per bit) so whole frames fit in a short run; all timing
// expectations are derived from that bit period.
// ----------------------------------------------------------------------------
module tb_rs232_echo_top;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 62_500;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int HALF     = CPB / 2;
    localparam int FRAME    = 10 * CPB;
    // Sync (2) + edge detect (1) + half bit + 9 bits + strobe (1).
    localparam int LATENCY  = HALF + 9 * CPB + 4;

    typedef struct {
        logic [7:0] data;
        int         startCycle;
        logic       startBit;
        logic       stopBit;
        int         badSamples;
    } frame_t;

    logic clk;
    logic rst_i;
    logic RXD_i;
    logic TXD_o;

    int     checks;
    int     errors;
    int     cycle;
    int     rxFallCycle;
    frame_t frames[$];

    logic [FRAME-1:0] monWave;
    frame_t           monFrame;

    rs232_echo_top #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .RXD_i (RXD_i),
        .TXD_o (TXD_o)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running cycle counter used for latency measurement.
    initial cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Hard limit so the run always ends.
    initial begin
        #400_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Line monitor: on every TXD fall, capture one frame's worth of samples,
    // decode mid-bit values and count samples that disagree with their bit.
    initial begin : txMonitor
        forever begin
            @(negedge clk);
            if (TXD_o === 1'b0 && rst_i === 1'b1) begin
                monWave[0]          = TXD_o;
                monFrame.startCycle = cycle;
                for (int k = 1; k < FRAME; k++) begin
                    @(negedge clk);
                    monWave[k] = TXD_o;
                end
                monFrame.startBit = monWave[HALF];
                monFrame.stopBit  = monWave[9 * CPB + HALF];
                for (int b = 0; b < 8; b++) begin
                    monFrame.data[b] = monWave[(b + 1) * CPB + HALF];
                end
                monFrame.badSamples = 0;
                for (int k = 0; k < FRAME; k++) begin
                    if (monWave[k] !== monWave[(k / CPB) * CPB + HALF]) begin
                        monFrame.badSamples++;
                    end
                end
                frames.push_back(monFrame);
            end
        end
    end

    // Drive one 8N1 frame on RXD, starting at a falling clock edge.
    task automatic applyStimulus(input logic [7:0] b, input logic stopVal);
        rxFallCycle = cycle;
        RXD_i = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RXD_i = b[i];
            repeat (CPB) @(negedge clk);
        end
        RXD_i = stopVal;
        repeat (CPB) @(negedge clk);
        RXD_i = 1'b1;
    endtask

    // Bounded wait for the monitor to collect n frames.
    task automatic waitFrames(input int n, input int budget, output bit ok);
        int c;
        c = 0;
        while (frames.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        ok = (frames.size() >= n);
    endtask

    task automatic test_reset();
        int lowSeen;
        rst_i = 1'b0;
        RXD_i = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (TXD_o !== 1'b1) begin
                errors++;
                $display("[TB] FAIL reset_txd cycle %0d: got %b expected 1", i, TXD_o);
            end
        end
        rst_i = 1'b1;
        lowSeen = 0;
        for (int i = 0; i < 4 * CPB; i++) begin
            @(negedge clk);
            if (TXD_o !== 1'b1) lowSeen++;
        end
        checks++;
        if (lowSeen != 0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got %0d non-high samples expected 0", lowSeen);
        end
    endtask

    task automatic test_single();
        bit ok;
        int lat;
        frames.delete();
        applyStimulus(8'h3D, 1'b1);
        waitFrames(1, 20 * CPB, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL single_timeout: got %0d frames expected 1", frames.size());
        end else begin
            checks++;
            if (frames[0].data !== 8'h3D) begin
                errors++;
                $display("[TB] FAIL single_data: got %h expected 3d", frames[0].data);
            end
            checks++;
            if (frames[0].startBit !== 1'b0 || frames[0].stopBit !== 1'b1) begin
                errors++;
                $display("[TB] FAIL single_framing: got start %b stop %b expected 0 1",
                         frames[0].startBit, frames[0].stopBit);
            end
            checks++;
            if (frames[0].badSamples != 0) begin
                errors++;
                $display("[TB] FAIL single_bit_length: got %0d off-bit samples expected 0",
                         frames[0].badSamples);
            end
            lat = frames[0].startCycle - rxFallCycle;
            checks++;
            if (lat < LATENCY - 3 || lat > LATENCY + 3) begin
                errors++;
                $display("[TB] FAIL single_latency: got %0d expected %0d +-3", lat, LATENCY);
            end
        end
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic test_two_frames();
        bit ok;
        frames.delete();
        applyStimulus(8'h3D, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        applyStimulus(8'h02, 1'b1);
        waitFrames(2, 20 * CPB, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL two_timeout: got %0d frames expected 2", frames.size());
        end else begin
            checks++;
            if (frames[0].data !== 8'h3D || frames[1].data !== 8'h02) begin
                errors++;
                $display("[TB] FAIL two_data: got %h %h expected 3d 02",
                         frames[0].data, frames[1].data);
            end
            checks++;
            if (frames[0].badSamples != 0 || frames[1].badSamples != 0 ||
                frames[1].stopBit !== 1'b1) begin
                errors++;
                $display("[TB] FAIL two_framing: got bad %0d %0d stop %b expected 0 0 1",
                         frames[0].badSamples, frames[1].badSamples, frames[1].stopBit);
            end
        end
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic test_glitch();
        frames.delete();
        RXD_i = 1'b0;
        repeat (4) @(negedge clk);
        RXD_i = 1'b1;
        repeat (14 * CPB) @(negedge clk);
        checks++;
        if (frames.size() != 0) begin
            errors++;
            $display("[TB] FAIL glitch_no_echo: got %0d frames expected 0", frames.size());
        end
    endtask

    task automatic test_framing();
        bit ok;
        frames.delete();
        applyStimulus(8'h81, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        applyStimulus(8'hA5, 1'b1);
        waitFrames(1, 20 * CPB, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL framing_timeout: got %0d frames expected 1", frames.size());
        end else begin
            checks++;
            if (frames[0].data !== 8'hA5 || frames[0].badSamples != 0) begin
                errors++;
                $display("[TB] FAIL framing_next_data: got %h bad %0d expected a5 bad 0",
                         frames[0].data, frames[0].badSamples);
            end
        end
        repeat (4 * CPB) @(negedge clk);
        checks++;
        if (frames.size() != 1) begin
            errors++;
            $display("[TB] FAIL framing_drop: got %0d frames expected 1", frames.size());
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        frames.delete();
        applyStimulus(8'h55, 1'b1);
        applyStimulus(8'hAA, 1'b1);
        waitFrames(2, 30 * CPB, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL b2b_timeout: got %0d frames expected 2", frames.size());
        end else begin
            checks++;
            if (frames[0].data !== 8'h55 || frames[1].data !== 8'hAA) begin
                errors++;
                $display("[TB] FAIL b2b_data: got %h %h expected 55 aa",
                         frames[0].data, frames[1].data);
            end
            checks++;
            if (frames[0].badSamples != 0 || frames[1].badSamples != 0) begin
                errors++;
                $display("[TB] FAIL b2b_bit_length: got bad %0d %0d expected 0 0",
                         frames[0].badSamples, frames[1].badSamples);
            end
        end
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic test_reset_mid_tx();
        bit ok;
        int c;
        frames.delete();
        applyStimulus(8'h3C, 1'b1);
        c = 0;
        while (TXD_o !== 1'b0 && c < 4 * CPB) begin
            @(negedge clk);
            c++;
        end
        repeat (4) @(negedge clk);
        checks++;
        if (TXD_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midtx_busy: got %b expected 0 (start bit)", TXD_o);
        end
        rst_i = 1'b0;
        @(negedge clk);
        checks++;
        if (TXD_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midtx_reset_edge: got %b expected 1", TXD_o);
        end
        repeat (3) @(negedge clk);
        rst_i = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        frames.delete();
        repeat (12 * CPB) @(negedge clk);
        checks++;
        if (frames.size() != 0) begin
            errors++;
            $display("[TB] FAIL midtx_no_resend: got %0d frames expected 0", frames.size());
        end
        applyStimulus(8'h96, 1'b1);
        waitFrames(1, 20 * CPB, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL after_reset_timeout: got %0d frames expected 1", frames.size());
        end else begin
            checks++;
            if (frames[0].data !== 8'h96 || frames[0].badSamples != 0) begin
                errors++;
                $display("[TB] FAIL after_reset_data: got %h bad %0d expected 96 bad 0",
                         frames[0].data, frames[0].badSamples);
            end
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rxFallCycle = 0;
        rst_i       = 1'b0;
        RXD_i       = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_two_frames();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_reset_mid_tx();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
